// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch state enum and instruction/entry widths
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ENTRY_W = 2 * INSTR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - 2-entry output buffer (output register + 1-entry skid) with flush
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    pop          = out_valid_q && out_ready_i;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || pop) begin
      // The skid entry is older than anything arriving now, so it moves up first.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = in_valid_i;
        if (in_valid_i) skid_data_d = in_data_i;
      end else begin
        out_valid_d = in_valid_i;
        if (in_valid_i) out_data_d = in_data_i;
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch with 1-cycle ROM, redirect and 2-entry output buffer
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_CHECK_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rom_read_enable,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [INSTR_W-1:0]    rom_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_W-1:0]    out_instr,
  output logic [31:0]           out_pc,
  output logic                  fetch_misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         misaligned_q, misaligned_d;

  logic [31:0]        redirect_tgt;
  logic               redirect_bad;
  logic [31:0]        fetch_addr;
  logic               flush;
  logic               accepted;
  logic [2:0]         occupancy;
  logic               buf_in_ready;
  logic               buf_out_valid;
  logic [ENTRY_W-1:0] buf_out_data;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign redirect_bad = |redirect_pc[1:0];
`else
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign redirect_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = rom_read_enable;
    inflight_pc_d = inflight_pc_q;
    misaligned_d  = misaligned_q;
    if (rom_read_enable) begin
      inflight_pc_d = fetch_addr;
      pc_d          = fetch_addr + 32'd4;
    end
    case (state_q)
      IDLE: state_d = RUN;
      RUN, HALT: begin
        if (redirect_valid) begin
          state_d      = redirect_bad ? HALT : RUN;
          misaligned_d = redirect_bad;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accepted        = buf_out_valid && out_ready;
    // Slots already claimed: in-flight word plus buffered entries, less the one leaving now.
    occupancy       = 3'(inflight_q) + 3'(buf_out_valid) + 3'(!buf_in_ready) - 3'(accepted);
    flush           = redirect_valid && (state_q != IDLE);
    fetch_addr      = pc_q;
    rom_read_enable = 1'b0;
    if (flush) begin
      fetch_addr      = redirect_tgt;
      rom_read_enable = !redirect_bad;
    end else if (state_q == RUN && occupancy < 3'd2) begin
      rom_read_enable = 1'b1;
    end
  end

  assign rom_address = fetch_addr[ADDR_WIDTH+1:2];

  fetch_skid_buf #(.W(ENTRY_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .in_valid_i (inflight_q && !flush),
    .in_ready_o (buf_in_ready),
    .in_data_i  ({rom_data, inflight_pc_q}),
    .out_valid_o(buf_out_valid),
    .out_ready_i(out_ready),
    .out_data_o (buf_out_data)
  );

  assign out_valid        = buf_out_valid;
  assign out_instr        = buf_out_data[ENTRY_W-1:INSTR_W];
  assign out_pc           = buf_out_data[31:0];
  assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch (ROM model, stall, redirect, wrap, reset)
module tb_instr_fetch;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rom_read_enable;
  logic [AW-1:0] rom_address;
  logic [31:0]   rom_data = '0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          fetch_misaligned;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rom_read_enable (rom_read_enable),
    .rom_address     (rom_address),
    .rom_data        (rom_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  always @(posedge clk) if (rom_read_enable) rom_data <= 32'hA000_0000 + 32'(rom_address);

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch_pc = '0;
  bit          no_strobe = 1'b0;
  bit          seen_10 = 1'b0;
  int          strobes = 0;
  int          cyc = 0;
  int          first_strobe = -1;
  int          first_valid = -1;

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'hA000_0000 + ((pc >> 2) & 32'((1 << AW) - 1));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (rom_read_enable) begin
      strobes++;
      if (first_strobe < 0) first_strobe = cyc;
      if (no_strobe) chk("strobe_forbidden", 64'(rom_read_enable), 64'd0);
      else chk("rom_address", 64'(rom_address), 64'(exp_fetch_pc[AW+1:2]));
      if (exp_fetch_pc == 32'h10) seen_10 = 1'b1;
      exp_fetch_pc += 32'd4;
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL scoreboard_empty observed=%0h expected=none", out_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_pc", 64'(out_pc), 64'(e));
        chk("out_instr", 64'(out_instr), 64'(exp_instr(e)));
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bit bad;
`ifdef FETCH_MISALIGN_CHECK_EN
    bad = |target[1:0];
`else
    bad = 1'b0;
`endif
    redirect_valid = 1'b1;
    redirect_pc    = target;
    no_strobe      = bad;
    if (!bad) exp_fetch_pc = {target[31:2], 2'b00};
    tick();
    redirect_valid = 1'b0;
    if (bad) exp_q.delete();
    else push_seq({target[31:2], 2'b00});
  endtask

  initial begin
    logic [31:0] pc_hold;
    int          s0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_rom_re", 64'(rom_read_enable), 64'd0);
    chk("rst_misaligned", 64'(fetch_misaligned), 64'd0);

    // Streaming from RESET_PC, past the ROM wrap at pc 0x3C -> 0x40
    push_seq(32'h0);
    exp_fetch_pc = 32'h0;
    rst_n = 1'b1;
    repeat (24) tick();
    chk("first_strobe_cycle", 64'(first_strobe), 64'd1);
    chk("issue_to_valid", 64'(first_valid - first_strobe), 64'd2);

    // Five-cycle stall: output held, no new strobes, no gap on resume
    out_ready = 1'b0;
    pc_hold   = out_pc;
    s0        = strobes;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_pc_hold", 64'(out_pc), 64'(pc_hold));
      tick();
    end
    chk("stall_strobes", 64'(strobes - s0), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("resume_no_gap", 64'(out_valid), 64'd1);
      tick();
    end

    // Async reset while stalled with two entries buffered
    out_ready = 1'b0;
    repeat (3) tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_pc", 64'(out_pc), 64'd0);
    chk("async_rst_rom_re", 64'(rom_read_enable), 64'd0);
    @(posedge clk);
    #1;
    push_seq(32'h0);
    exp_fetch_pc = 32'h0;
    out_ready    = 1'b1;
    cyc          = 0;
    first_strobe = -1;
    first_valid  = -1;
    seen_10      = 1'b0;
    rst_n        = 1'b1;

    // Restart, then redirect to 0x40 while 0x10 is in flight
    for (int i = 0; i < 20 && !seen_10; i++) tick();
    chk("saw_strobe_0x10", 64'(seen_10), 64'd1);
    chk("restart_issue_to_valid", 64'(first_valid - first_strobe), 64'd2);
    redirect(32'h40);
    chk("redirect_flush", 64'(out_valid), 64'd0);
    tick();
    chk("redirect_valid_2cyc", 64'(out_valid), 64'd1);
    chk("redirect_first_pc", 64'(out_pc), 64'h40);
    repeat (6) tick();

    // Misaligned redirect target
    redirect(32'h22);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misaligned_set", 64'(fetch_misaligned), 64'd1);
    chk("halt_no_valid", 64'(out_valid), 64'd0);
    repeat (4) tick();
    chk("halt_hold_flag", 64'(fetch_misaligned), 64'd1);
    chk("halt_hold_no_valid", 64'(out_valid), 64'd0);
    redirect(32'h20);
    chk("misaligned_cleared", 64'(fetch_misaligned), 64'd0);
`else
    chk("misaligned_tied", 64'(fetch_misaligned), 64'd0);
`endif
    tick();
    chk("aligned_valid", 64'(out_valid), 64'd1);
    chk("aligned_pc", 64'(out_pc), 64'h20);
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, ROM word-address width (256 words).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch byte address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rom_read_enable  output  1  ROM read strobe.
REQ-006 SHALL have port rom_address  output  ADDR_WIDTH  ROM word address = pc[ADDR_WIDTH+1:2].
REQ-007 SHALL have port rom_data  input  32  ROM read data, valid the cycle after a strobe.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-010 SHALL have port out_valid  output  1  instruction available to decode.
REQ-011 SHALL have port out_ready  input  1  decode accepts; transfer when out_valid && out_ready.
REQ-012 SHALL have port out_instr  output  32  fetched instruction.
REQ-013 SHALL have port out_pc  output  32  byte address of out_instr.
REQ-014 SHALL have port fetch_misaligned  output  1  misaligned redirect flag.

Function
REQ-015 ROM latency SHALL be exactly 1 cycle; the fetch SHALL track one in-flight request (flag + PC) and capture rom_data only in the cycle after its strobe.
REQ-016 Issue-to-out_valid latency SHALL be 2 cycles; out_instr/out_pc registered.
REQ-017 Output buffering SHALL hold 2 entries (output register + 1-entry skid); strobe issued only if in-flight + occupied − accepted-this-cycle < 2.
REQ-018 With out_ready held high, throughput SHALL be one instruction per cycle, in PC order, no drops or duplicates.
REQ-019 out_valid/out_instr/out_pc SHALL stay stable while out_valid && !out_ready.
REQ-020 Sequential PC SHALL advance by 4 modulo 2^32 per issued strobe; rom_address wraps from 2^ADDR_WIDTH−1 to 0.
REQ-021 redirect_valid SHALL have priority over all other events: same cycle, drop output register, skid and in-flight response; strobe at redirect_pc; pc <= redirect_pc+4.
REQ-022 Redirect with simultaneous out_valid && out_ready SHALL count that transfer as accepted; nothing fetched before the redirect appears afterwards.
REQ-023 State machine SHALL be IDLE (reset) -> RUN (first cycle after rst_n high) -> HALT (misaligned only); HALT -> RUN on aligned redirect.
REQ-024 No strobe SHALL be issued in IDLE or HALT.

Reset
REQ-025 During rst_n low: out_valid=0, out_instr=0, out_pc=0, rom_read_enable=0, fetch_misaligned=0, pc=RESET_PC, buffers and in-flight empty, state IDLE.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight and buffered data immediately (asynchronous).

Configuration
REQ-027 With FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 SHALL flush, issue no strobe, set fetch_misaligned=1 and enter HALT until next aligned redirect, which clears the flag.
REQ-028 Without FETCH_MISALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 0, fetch_misaligned tied 0, HALT unreachable.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the state enum (IDLE/RUN/HALT) and the instruction-width constant (32).
REQ-030 The 2-entry output buffer SHALL be sub-module fetch_skid_buf (valid/ready both sides, width 64: instr+pc).

Verification
REQ-031 Reset release, RESET_PC=0, out_ready=1, ROM word k = 0xA000_0000+k -> out_valid first at cycle 2, then out_pc 0,4,8,... with matching out_instr every cycle.
REQ-032 out_ready low for 5 cycles mid-stream -> out_valid held, no strobes beyond 2-entry capacity, resume with no gap or duplicate.
REQ-033 redirect to 0x40 while instr at 0x10 in flight -> 0x10/0x14 never delivered; next delivered out_pc=0x40 two cycles after redirect.
REQ-034 ADDR_WIDTH=4, run past pc 0x3C -> rom_address wraps 15 -> 0, out_pc continues 0x40.
REQ-035 Macro defined, redirect to 0x22 -> fetch_misaligned=1, no strobes, out_valid=0; redirect to 0x20 -> flag clears, out_pc 0x20 delivered.
REQ-036 rst_n pulsed low while stalled with 2 entries buffered -> out_valid=0 asynchronously; restart from RESET_PC.
